mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 29 ++
 rtl/mult_div_core_div.sv | 53 +++++
 rtl/mult_div_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared op and state encodings for the multiply/divide unit.
// The op encoding matches the decoder's mudiOp field.
package mult_div_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_FDIV  = 3'b110,
        MD_NOP   = 3'b111
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_mult(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return (op != MD_MULTU) && (op != MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_core_div.sv
// Combinational divider on latched operands: div, divu and (with MULT_DIV_FDIV_EN)
// fixed-point fdiv. Quotient truncates toward zero; remainder takes the dividend's sign.
module mult_div_core_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero
);

    localparam int W2 = 2 * WIDTH;

    logic          signed_op;
    logic          neg_n;
    logic          neg_d;
    logic [W2-1:0] dividend;
    logic [W2-1:0] divisor;
    logic [W2-1:0] mag_n;
    logic [W2-1:0] mag_d;
    logic [W2-1:0] q_mag;
    logic [W2-1:0] r_mag;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        signed_op = (op != MD_DIVU);
        dividend  = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
`ifdef MULT_DIV_FDIV_EN
        if (op == MD_FDIV) begin
            dividend = {{WIDTH{a[WIDTH-1]}}, a} << (WIDTH / 2);
        end
`endif
        divisor  = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        neg_n    = signed_op & dividend[W2-1];
        neg_d    = signed_op & divisor[W2-1];
        mag_n    = neg_n ? -dividend : dividend;
        mag_d    = neg_d ? -divisor  : divisor;
        div_zero = (b == '0);
        // A zero divisor never commits; substitute 1 to keep the datapath X-free.
        if (div_zero) begin
            mag_d = {{(W2-1){1'b0}}, 1'b1};
        end
        q_mag     = mag_n / mag_d;
        r_mag     = mag_n % mag_d;
        quotient  = (neg_n ^ neg_d) ? -q_mag[WIDTH-1:0] : q_mag[WIDTH-1:0];
        remainder = neg_n ? -r_mag[WIDTH-1:0] : r_mag[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit with fixed-latency sequencing, flush and mthi/mtlo.
// Op 110 (fdiv) is only decoded when MULT_DIV_FDIV_EN is defined.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             sel_hi,
    output logic             busy,
    output logic [WIDTH-1:0] rd_data
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t MULT_LOAD = cnt_t'(MULT_CYCLES - 1);
    localparam cnt_t DIV_LOAD  = cnt_t'(DIV_CYCLES - 1);

    md_state_e          state;
    cnt_t               cnt;
    md_op_e             op_in;
    md_op_e             op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               accept;
    logic               launch;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               div_zero;

    always_comb begin
        op_in  = md_op_e'(op);
        accept = start && !flush && (state == ST_IDLE);
        unique case (op_in)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: launch = 1'b1;
`ifdef MULT_DIV_FDIV_EN
            MD_FDIV: launch = 1'b1;
`endif
            default: launch = 1'b0;
        endcase
    end

    // The low 2*WIDTH bits of an extended product are exact for both signednesses.
    always_comb begin
        ext_a   = is_signed_op(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b   = is_signed_op(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product = ext_a * ext_b;
    end

    mult_div_core_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= MD_NOP;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_in == MD_MTHI) hi <= a;
                        if (op_in == MD_MTLO) lo <= a;
                        if (launch) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            op_q  <= op_in;
                            a_q   <= a;
                            b_q   <= b;
                            cnt   <= is_mult(op_in) ? MULT_LOAD : DIV_LOAD;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (is_mult(op_q)) begin
                            {hi, lo} <= product;
                        end else if (!div_zero) begin
                            hi <= remainder;
                            lo <= quotient;
                        end
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
            endcase
        end
    end

    assign rd_data = sel_hi ? hi : lo;

endmodule
